// File: rtl/out_hex_display.sv
`default_nettype none
// ============================================================================
//  Module   : out_hex_display
//  Purpose  : Latches the CPU Out word on a write strobe and shows it as four
//             hex digits on a time-multiplexed, common-anode 7-segment
//             display (active-low anodes, segments and decimal point).
//  Revision : 1.0  initial release
// ============================================================================
module out_hex_display #(
  parameter int REFRESH_DIV = 50000,  // sclk cycles each digit stays enabled
  parameter bit LEAD_BLANK  = 1'b1    // 1 = blank leading zero digits 3..1
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic [15:0] out_data,
  input  logic        out_we,
  output logic [15:0] value,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  // Divider width never drops below one bit, even for REFRESH_DIV = 1.
  localparam int              DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_OFF  = 7'b1111111;

  // Hex digit to active-low segment pattern, ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [15:0]      value_q, value_d;
  logic             upd_q,   upd_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q,   idx_d;
  logic [3:0]       an_q,    an_d;
  logic [6:0]       seg_q,   seg_d;
  logic             dp_q,    dp_d;

  logic [3:0]       nib_sel;
  logic [3:0]       blank;

  // Capture the CPU word on every strobed edge; upd flips on each capture so
  // the digit-0 decimal point shows that a new write has arrived.
  always_comb begin
    value_d = value_q;
    upd_d   = upd_q;
    if (out_we) begin
      value_d = out_data;
      upd_d   = ~upd_q;
    end
  end

  // Refresh divider and digit index; the index steps when the divider wraps.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end
  end

  // Leading-zero blanking: a digit is dark when it and every higher nibble
  // are zero. Digit 0 always stays lit so a zero word still shows "0".
  always_comb begin
    blank    = 4'b0000;
    blank[3] = LEAD_BLANK && (value_q[15:12] == 4'h0);
    blank[2] = blank[3]   && (value_q[11:8]  == 4'h0);
    blank[1] = blank[2]   && (value_q[7:4]   == 4'h0);
  end

  // Select the nibble for the digit currently being scanned.
  always_comb begin
    case (idx_q)
      2'd0:    nib_sel = value_q[3:0];
      2'd1:    nib_sel = value_q[7:4];
      2'd2:    nib_sel = value_q[11:8];
      default: nib_sel = value_q[15:12];
    endcase
  end

  // Next display drive is built from the state held after the previous edge,
  // so a capture shows up on the pins one edge later.
  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank[idx_q] ? SEG_OFF : decode(nib_sel);
    dp_d  = (idx_q == 2'd0) ? ~upd_q : 1'b1;
  end

  // State and output registers; reset wins over any pending strobe.
  always_ff @(posedge sclk) begin
    if (rst) begin
      value_q   <= 16'h0000;
      upd_q     <= 1'b0;
      div_cnt_q <= '0;
      idx_q     <= 2'd0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
    end else begin
      value_q   <= value_d;
      upd_q     <= upd_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign value = value_q;
  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_out_hex_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_out_hex_display
//  Purpose  : Directed self-checking bench for out_hex_display. Three copies
//             share stimulus: REFRESH_DIV=4 with blanking, REFRESH_DIV=4
//             without blanking, and REFRESH_DIV=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_out_hex_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] out_data = 16'h0000;
  logic        out_we = 1'b0;

  logic [15:0] a_value, b_value, c_value;
  logic [3:0]  a_an, b_an, c_an;
  logic [6:0]  a_seg, b_seg, c_seg;
  logic        a_dp, b_dp, c_dp;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] S_OFF = 7'b1111111;
  localparam logic [6:0] S_0   = 7'b1000000;
  localparam logic [6:0] S_1   = 7'b1111001;
  localparam logic [6:0] S_2   = 7'b0100100;
  localparam logic [6:0] S_3   = 7'b0110000;
  localparam logic [6:0] S_5   = 7'b0010010;
  localparam logic [6:0] S_A   = 7'b0001000;
  localparam logic [6:0] S_F   = 7'b0001110;

  always #5 clk = ~clk;

  out_hex_display #(.REFRESH_DIV(4), .LEAD_BLANK(1'b1)) u_a (
    .sclk(clk), .rst(rst), .out_data(out_data), .out_we(out_we),
    .value(a_value), .an(a_an), .seg(a_seg), .dp(a_dp)
  );

  out_hex_display #(.REFRESH_DIV(4), .LEAD_BLANK(1'b0)) u_b (
    .sclk(clk), .rst(rst), .out_data(out_data), .out_we(out_we),
    .value(b_value), .an(b_an), .seg(b_seg), .dp(b_dp)
  );

  out_hex_display #(.REFRESH_DIV(1), .LEAD_BLANK(1'b1)) u_c (
    .sclk(clk), .rst(rst), .out_data(out_data), .out_we(out_we),
    .value(c_value), .an(c_an), .seg(c_seg), .dp(c_dp)
  );

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and capture d on the first edge after release (E1).
  task automatic restart_with(input logic [15:0] d);
    rst = 1'b1; out_we = 1'b0;
    tick();
    rst = 1'b0; out_we = 1'b1; out_data = d;
    tick();
    out_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_we = 1'b0;
    tick(); tick();
    tests++;
    if ({a_an, a_seg, a_dp, a_value} !== {4'b1111, S_OFF, 1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL reset_state: an=%b seg=%b dp=%b value=%h expected an=1111 seg=1111111 dp=1 value=0000",
               a_an, a_seg, a_dp, a_value);
    end
    tests++;
    if ({c_an, c_value, b_an, b_value} !== {4'b1111, 16'h0, 4'b1111, 16'h0}) begin
      fails++;
      $display("FAIL reset_other: b_an=%b b_value=%h c_an=%b c_value=%h expected 1111/0000",
               b_an, b_value, c_an, c_value);
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({a_an, a_seg, a_dp} !== {4'b1110, S_0, 1'b1}) begin
      fails++;
      $display("FAIL reset_release: an=%b seg=%b dp=%b expected an=1110 seg=1000000 dp=1",
               a_an, a_seg, a_dp);
    end
  endtask

  task automatic test_scan();
    logic [3:0] an_exp  [4];
    logic [6:0] seg_exp [4];
    logic       dp_exp  [4];
    an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_exp = '{S_F, S_2, S_A, S_1};
    dp_exp  = '{1'b0, 1'b1, 1'b1, 1'b1};
    restart_with(16'h1A2F);
    tests++;
    if (a_value !== 16'h1A2F) begin
      fails++;
      $display("FAIL scan_value: value=%h expected 1a2f", a_value);
    end
    // Edge n shows idx (n-1)/4; walk E2..E17.
    for (int n = 2; n <= 17; n++) begin
      int i;
      tick();
      i = ((n - 1) / 4) % 4;
      tests++;
      if ({a_an, a_seg, a_dp} !== {an_exp[i], seg_exp[i], dp_exp[i]}) begin
        fails++;
        $display("FAIL scan_E%0d: an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                 n, a_an, a_seg, a_dp, an_exp[i], seg_exp[i], dp_exp[i]);
      end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] pat     [3];
    logic [6:0]  seg_exp [3][4];
    pat     = '{16'h0005, 16'h0500, 16'h0000};
    seg_exp = '{'{S_5, S_OFF, S_OFF, S_OFF},
                '{S_0, S_0,   S_5,   S_OFF},
                '{S_0, S_OFF, S_OFF, S_OFF}};
    for (int p = 0; p < 3; p++) begin
      restart_with(pat[p]);
      for (int n = 2; n <= 17; n++) begin
        int i;
        tick();
        i = ((n - 1) / 4) % 4;
        tests++;
        if (a_seg !== seg_exp[p][i]) begin
          fails++;
          $display("FAIL blank_%h_digit%0d: seg=%b expected %b", pat[p], i, a_seg, seg_exp[p][i]);
        end
      end
    end
  endtask

  task automatic test_no_blanking();
    logic [6:0] seg_exp [4];
    seg_exp = '{S_5, S_0, S_0, S_0};
    restart_with(16'h0005);
    for (int n = 2; n <= 17; n++) begin
      int i;
      tick();
      i = ((n - 1) / 4) % 4;
      tests++;
      if (b_seg !== seg_exp[i]) begin
        fails++;
        $display("FAIL noblank_digit%0d: seg=%b expected %b", i, b_seg, seg_exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; tick();
    rst = 1'b0;
    out_we = 1'b1;
    out_data = 16'h1111; tick();
    out_data = 16'h2222; tick();
    out_data = 16'h3333; tick();
    out_we = 1'b0;
    tests++;
    if (a_value !== 16'h3333) begin
      fails++;
      $display("FAIL back_to_back_value: value=%h expected 3333", a_value);
    end
  endtask

  task automatic test_write_on_wrap();
    rst = 1'b1; tick();
    rst = 1'b0;
    tick(); tick(); tick();            // E1..E3, divider now at 3
    out_we = 1'b1; out_data = 16'h1234;
    tick();                            // E4: capture and idx step together
    out_we = 1'b0;
    tests++;
    if ({a_an, a_seg} !== {4'b1110, S_0}) begin
      fails++;
      $display("FAIL wrap_E4: an=%b seg=%b expected an=1110 seg=1000000", a_an, a_seg);
    end
    tick();
    tests++;
    if ({a_an, a_seg} !== {4'b1101, S_3}) begin
      fails++;
      $display("FAIL wrap_E5: an=%b seg=%b expected an=1101 seg=0110000", a_an, a_seg);
    end
  endtask

  task automatic test_dp_toggle();
    logic dp_exp [3];
    dp_exp = '{1'b1, 1'b0, 1'b1};
    rst = 1'b1; tick();
    rst = 1'b0;
    out_we = 1'b1; out_data = 16'h0042;
    for (int n = 1; n <= 3; n++) begin
      tick();
      if (n == 2) out_we = 1'b0;
      tests++;
      if (a_dp !== dp_exp[n-1]) begin
        fails++;
        $display("FAIL dp_toggle_E%0d: dp=%b expected %b", n, a_dp, dp_exp[n-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    restart_with(16'h1234);            // E1
    for (int n = 2; n <= 9; n++) tick();
    tests++;
    if ({a_value, a_an} !== {16'h1234, 4'b1011}) begin
      fails++;
      $display("FAIL mid_pre: value=%h an=%b expected value=1234 an=1011", a_value, a_an);
    end
    rst = 1'b1; out_we = 1'b1; out_data = 16'hBEEF;
    tick();
    tests++;
    if ({a_an, a_seg, a_dp, a_value} !== {4'b1111, S_OFF, 1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL mid_reset: an=%b seg=%b dp=%b value=%h expected 1111/1111111/1/0000",
               a_an, a_seg, a_dp, a_value);
    end
    rst = 1'b0; out_we = 1'b0;
    tick();
    tests++;
    if ({a_an, a_seg, a_dp, a_value} !== {4'b1110, S_0, 1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL mid_restart: an=%b seg=%b dp=%b value=%h expected 1110/1000000/1/0000",
               a_an, a_seg, a_dp, a_value);
    end
    tick(); tick(); tick();
    tests++;
    if (a_an !== 4'b1110) begin
      fails++;
      $display("FAIL mid_hold: an=%b expected 1110", a_an);
    end
    tick();
    tests++;
    if ({a_an, a_seg} !== {4'b1101, S_OFF}) begin
      fails++;
      $display("FAIL mid_step: an=%b seg=%b expected an=1101 seg=1111111", a_an, a_seg);
    end
  endtask

  task automatic test_div1();
    logic [3:0] an_exp [4];
    an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      tests++;
      if (c_an !== an_exp[(n-1) % 4]) begin
        fails++;
        $display("FAIL div1_E%0d: an=%b expected %b", n, c_an, an_exp[(n-1) % 4]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_no_blanking();
    test_back_to_back();
    test_write_on_wrap();
    test_dp_toggle();
    test_reset_mid();
    test_div1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
